conv_first_to_last_with_len: RTL
================================

Name: conv_first_to_last_with_len

Overview:
Downstream neighbour of the last-to-first converter. Consumes a valid/first/data stream and re-marks it as a valid/last/data stream. It holds one word until the next word or a flush shows whether that word ends its packet. It also reports each packet's word count alongside the last word, and flags words that arrive without a packet having been opened.

Parameters:
width, 8, data bus width in bits
len_width, 8, packet length counter width; count saturates at 2**len_width-1

Ports:
clock  input  1  single clock, all state on posedge
reset  input  1  synchronous, active-high reset
up_valid  input  1  upstream word present this cycle (no backpressure)
up_first  input  1  upstream word is first of a packet; meaningful only with up_valid
up_data  input  width  upstream word
flush  input  1  close the currently open packet without waiting for the next first
down_valid  output  1  downstream word present this cycle
down_last  output  1  downstream word is last of its packet; qualified by down_valid
down_data  output  width  downstream word (content of the hold register)
down_len  output  len_width  word count of the packet ending now; qualified by down_valid && down_last, 0 otherwise
up_error  output  1  one-cycle pulse: previous cycle accepted a non-first word with no packet open

Behaviour:
- Interface decided: one clock named clock; reset named reset, synchronous, active-high.
- State:
  - hold_valid, hold_data: one-entry hold register.
  - pkt_cnt[len_width]: words accepted in the open packet, including the held word.
  - err_r: registered error pulse.
- Open packet exists iff hold_valid=1.
- Reset (sampled at posedge): hold_valid=0, pkt_cnt=0, err_r=0. Any held word is dropped, no output.
- While reset=1: down_valid=0, down_last=0, down_len=0, up_error=0.
- Combinational outputs:
  - down_valid = hold_valid && (up_valid || flush).
  - down_data = hold_data.
  - down_last = down_valid && (flush || up_first).
  - down_len = down_last ? pkt_cnt : 0.
- Latency: each word appears downstream on the cycle the next up_valid or flush arrives. It is held indefinitely otherwise.
- Per-cycle update (priority order):
  1. up_valid=1, flush=0, hold_valid=1, up_first=1: emit held word with last=1 and down_len=pkt_cnt. Store the new word; pkt_cnt=1.
  2. up_valid=1, flush=0, hold_valid=1, up_first=0: emit held word with last=0. Store the new word; pkt_cnt=sat(pkt_cnt+1).
  3. up_valid=1, flush=1, hold_valid=1: emit held word with last=1, down_len=pkt_cnt. Store the new word as the start of a new packet regardless of up_first; pkt_cnt=1; no error.
  4. up_valid=1, hold_valid=0: nothing emitted. Store the word; pkt_cnt=1.
     - If up_first=0 and flush=0, set err_r=1 for the next cycle. The word is still treated as a packet start.
  5. up_valid=0, flush=1, hold_valid=1: emit held word with last=1, down_len=pkt_cnt. hold_valid=0; pkt_cnt=0.
  6. flush=1 with hold_valid=0 and up_valid=0: no-op.
  7. Otherwise: hold state unchanged.
- err_r clears every cycle it is not set. up_error = err_r.
- Saturation: pkt_cnt never wraps. A packet longer than the maximum reports down_len = 2**len_width-1.
- At most one word is emitted per cycle, so there is no overflow case.
- A packet length is never 0 when down_last=1.

Decomposition:
- No shared package needed. Keep width/len_width as module parameters only.
- An optional sub-module sat_counter (parameter len_width; inputs clear, load_one, inc; output count) is natural for pkt_cnt.
- Everything else stays in a single module, roughly 120-180 lines.

Test Plan:
- Reset, then words A(first=1), B(first=0), C(first=0), D(first=1) on consecutive cycles. Expect:
  - Nothing on the A cycle.
  - A/last=0, then B/last=0, then C/last=1 with down_len=3 on the D cycle.
- Single-word packets: first=1 words X, Y, Z, then flush. Expect X(len=1), Y(len=1), Z(len=1), each with last=1. Z is emitted on the flush cycle.
- Idle gaps: A(first=1), 5 idle cycles, B(first=0), 3 idle cycles, flush. Expect:
  - down_valid=0 during idles.
  - A/last=0 on the B cycle; B/last=1 with len=2 on the flush cycle.
- Simultaneous flush+up_valid: open packet holding P (pkt_cnt=2); Q arrives with first=0 and flush=1. Expect:
  - P emitted with last=1, len=2.
  - Q held as a new packet with up_error=0.
  - A later first=1 word emits Q with last=1, len=1.
- Protocol error and saturation:
  - After reset, a first=0 word arrives: up_error pulses exactly one cycle later.
  - With len_width=3, a 10-word packet ends with down_len=7.
- Reset mid-packet: hold 3 words, assert reset for 1 cycle. Expect no output during or after reset. The next first=1 word starts a packet with len=1 at its close.

Source files
------------

// File: rtl/conv_first_to_last_with_len_pkg.sv
// Shared types for the first-to-last stream converter.
// Names the per-cycle hold-register action so the top and the bench agree.
package conv_first_to_last_with_len_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_SPLIT,
        ACT_APPEND,
        ACT_RESTART,
        ACT_OPEN,
        ACT_CLOSE
    } act_e;

    // True when the held word leaves on this cycle.
    function automatic logic act_emits(input act_e a);
        return (a == ACT_SPLIT) || (a == ACT_APPEND) ||
               (a == ACT_RESTART) || (a == ACT_CLOSE);
    endfunction

    // True when the held word is the last of its packet.
    function automatic logic act_closes(input act_e a);
        return (a == ACT_SPLIT) || (a == ACT_RESTART) ||
               (a == ACT_CLOSE);
    endfunction

    // True when the incoming word starts a fresh packet count.
    function automatic logic act_loads(input act_e a);
        return (a == ACT_SPLIT) || (a == ACT_RESTART) ||
               (a == ACT_OPEN);
    endfunction

endpackage

// File: rtl/conv_first_to_last_with_len_sat_counter.sv
// Saturating packet word counter.
// Priority: clear, then load_one, then increment (sticks at all-ones).
module sat_counter #(
    parameter int len_width = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load_one,
    input  logic                 inc,
    output logic [len_width-1:0] count
);

    localparam logic [len_width-1:0] CNT_MAX = '1;
    localparam logic [len_width-1:0] CNT_ONE = len_width'(1);

    logic [len_width-1:0] count_q;
    logic [len_width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load_one) begin
            count_d = CNT_ONE;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/conv_first_to_last_with_len.sv
// Re-marks a valid/first stream as valid/last by holding one word
// until the next word or a flush reveals whether it closes its packet.
module conv_first_to_last_with_len
    import conv_first_to_last_with_len_pkg::*;
#(
    parameter int width     = 8,
    parameter int len_width = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 up_valid,
    input  logic                 up_first,
    input  logic [width-1:0]     up_data,
    input  logic                 flush,
    output logic                 down_valid,
    output logic                 down_last,
    output logic [width-1:0]     down_data,
    output logic [len_width-1:0] down_len,
    output logic                 up_error
);

    logic                 hold_valid_q;
    logic                 hold_valid_d;
    logic [width-1:0]     hold_data_q;
    logic [width-1:0]     hold_data_d;
    logic                 err_q;
    logic                 err_d;
    logic [len_width-1:0] pkt_cnt;
    logic                 cnt_clear;
    logic                 cnt_load;
    logic                 cnt_inc;
    act_e                 act;

    always_comb begin
        act = ACT_HOLD;
        if (up_valid && hold_valid_q && !flush && up_first) begin
            act = ACT_SPLIT;
        end else if (up_valid && hold_valid_q && !flush) begin
            act = ACT_APPEND;
        end else if (up_valid && hold_valid_q) begin
            act = ACT_RESTART;
        end else if (up_valid) begin
            act = ACT_OPEN;
        end else if (flush && hold_valid_q) begin
            act = ACT_CLOSE;
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        err_d        = 1'b0;
        unique case (act)
            ACT_SPLIT, ACT_APPEND, ACT_RESTART: begin
                hold_data_d = up_data;
            end
            ACT_OPEN: begin
                hold_valid_d = 1'b1;
                hold_data_d  = up_data;
                // A stray continuation word still opens a packet.
                err_d        = !up_first && !flush;
            end
            ACT_CLOSE: begin
                hold_valid_d = 1'b0;
            end
            default: begin
                hold_valid_d = hold_valid_q;
            end
        endcase
    end

    assign cnt_clear = reset || (act == ACT_CLOSE);
    assign cnt_load  = act_loads(act);
    assign cnt_inc   = (act == ACT_APPEND);

    sat_counter #(
        .len_width(len_width)
    ) u_cnt (
        .clock   (clock),
        .clear   (cnt_clear),
        .load_one(cnt_load),
        .inc     (cnt_inc),
        .count   (pkt_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            err_q        <= err_d;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign down_valid = !reset && act_emits(act);
    assign down_last  = !reset && act_closes(act);
    assign down_data  = hold_data_q;
    assign down_len   = down_last ? pkt_cnt : '0;
    assign up_error   = !reset && err_q;

endmodule
